disaggregator: RTL and testbench
================================

# disaggregator

Width-splitting stage for the streaming I/O path: pops one wide word of up to `FETCH_WIDTH` packed `DATA_WIDTH` slices from an upstream first-word-fall-through FIFO and emits the slices one per cycle, lowest slice first, into a narrow downstream FIFO. It is the reverse of `aggregator` and sits on the output side, for example leaf indices or results leaving the kd-tree toward the async output FIFO. The runtime fetch width is reconfigurable with the same `change_fetch_width` / `input_fetch_width` pair as the aggregator.

## Interface
Parameters:
- `DATA_WIDTH`, 11: width of one narrow slice.
- `FETCH_WIDTH`, 2: maximum slices per wide word.

Ports:
- `clk`, in, 1: sole clock.
- `rst`, in, 1: synchronous reset, active-high.
- `sender_data`, in, `FETCH_WIDTH*DATA_WIDTH`: wide word at the head of the upstream FIFO. Slice i is bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `sender_empty_n`, in, 1: upstream FIFO holds data.
- `sender_deq`, out, 1: pops the upstream head this cycle.
- `receiver_data`, out, `DATA_WIDTH`: current narrow slice.
- `receiver_full_n`, in, 1: downstream FIFO can accept.
- `receiver_enq`, out, 1: pushes `receiver_data` this cycle.
- `change_fetch_width`, in, 1: level request to load a new fetch width.
- `input_fetch_width`, in, 3: requested slices per word.

## Operation
- State: wide buffer `buf_q`, remaining-slice count `cnt_q` (0..`FETCH_WIDTH`), active width `fw_q`.
- Two states:
  - EMPTY: `cnt_q`=0.
  - DRAIN: `cnt_q`>0.
- `receiver_data` = `buf_q[DATA_WIDTH-1:0]`.
- `receiver_enq` = (`cnt_q`≠0) && `receiver_full_n`.
- On `receiver_enq`: `buf_q` shifts right by `DATA_WIDTH` with zero fill, and `cnt_q` decrements.
- `sender_deq` = `sender_empty_n` && !`change_fetch_width` && (`cnt_q`==0 || (`cnt_q`==1 && `receiver_enq`)).
- On `sender_deq`: `buf_q` ← `sender_data` and `cnt_q` ← `fw_q`. This load overrides the shift and decrement.
- Only the low `fw_q` slices are emitted. Upper slices are ignored.
- Width change applies when `change_fetch_width`=1 and `cnt_q`==0: `fw_q` ← `input_fetch_width`. A value of 0 or >`FETCH_WIDTH` clamps to `FETCH_WIDTH`.
- While `change_fetch_width`=1, no dequeue occurs. An in-progress drain completes under the old width.
- `rst`: `cnt_q`←0, `buf_q`←0, `fw_q`←`FETCH_WIDTH`.

## Timing
- Reset values: `sender_deq`=0, `receiver_enq`=0, `receiver_data`=0. Both handshake outputs are forced 0 while `rst`=1.
- Latency: the first slice is visible, and `receiver_enq` can assert, 1 cycle after the `sender_deq` edge.
- Throughput: 1 slice per cycle sustained. The last slice of word N and the load of word N+1 share a cycle, so there is no bubble.
- Downstream full (`receiver_full_n`=0): `buf_q` and `cnt_q` hold, and no dequeue occurs, including when `cnt_q`==1.
- Upstream empty: DRAIN finishes the current word and then idles in EMPTY with `receiver_enq`=0.
- Both handshakes are combinational from registered state plus `sender_empty_n`, `receiver_full_n` and `change_fetch_width`. No combinational path exists from `sender_data`.
- `rst` mid-drain: remaining slices are discarded. Nothing is emitted in the cycle after reset.

## Structure
- Shared package `fieldious_io_pkg` holds:
  - the `DATA_WIDTH`/`FETCH_WIDTH` defaults;
  - the fetch-width encoding width (3);
  - a `fetch_width_t` typedef;
  - the clamp function, shared with `aggregator`.
- Single module. No sub-module is needed; slice selection is the low bits of a shift register.

## Test plan
- Single word `sender_data`={11'd2,11'd1}, `fw`=2, `receiver_full_n`=1: `receiver_enq` on 2 consecutive cycles with data 1 then 2, then idle; exactly one `sender_deq`.
- Back-to-back words {2,1},{4,3},{6,5} with the upstream FIFO never empty: 6 consecutive `receiver_enq` carrying 1,2,3,4,5,6 with no gap; `sender_deq` asserted in cycles 0, 2 and 4 of the stream.
- Random `receiver_full_n` (50%) over 64 words: output sequence equals the reference unpacked stream, with no loss or duplication and no `receiver_enq` while `receiver_full_n`=0.
- Width change to 1 while in EMPTY, then word {11'd7,11'd9}: only 9 is emitted, one slice per `sender_deq`. Width change to 0 clamps to 2.
- `change_fetch_width` raised mid-drain after slice 1 of {2,1}: slice 2 is still emitted, the new width applies afterwards, and there is no dequeue while the request is high.
- `rst` asserted with `cnt_q`=1: the next cycle has `receiver_enq`=0, `sender_deq`=0 and `receiver_data`=0; after release, the next word starts at slice 0.

Source files
------------

// File: rtl/fieldious_io_pkg.sv
// rtl/fieldious_io_pkg.sv - shared widths, fetch-width type and clamp for the streaming I/O stages
package fieldious_io_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 11;
  localparam int DEFAULT_FETCH_WIDTH = 2;
  localparam int FW_ENC_WIDTH        = 3;

  typedef logic [FW_ENC_WIDTH-1:0] fetch_width_t;

  typedef enum logic {
    ST_EMPTY,
    ST_DRAIN
  } drain_state_t;

  // A zero or oversized request falls back to the full hardware width
  function automatic fetch_width_t clamp_fetch_width(input fetch_width_t req,
                                                     input fetch_width_t max_w);
    if (req == '0 || req > max_w) return max_w;
    return req;
  endfunction

endpackage

// File: rtl/disaggregator_if.sv
// rtl/disaggregator_if.sv - wide upstream FIFO head plus narrow downstream FIFO push
interface disaggregator_if
  import fieldious_io_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int FETCH_WIDTH = DEFAULT_FETCH_WIDTH
);

  logic [FETCH_WIDTH*DATA_WIDTH-1:0] sender_data;
  logic                              sender_empty_n;
  logic                              sender_deq;
  logic [DATA_WIDTH-1:0]             receiver_data;
  logic                              receiver_full_n;
  logic                              receiver_enq;

  modport master (
    output sender_data, sender_empty_n, receiver_full_n,
    input  sender_deq, receiver_data, receiver_enq
  );

  modport slave (
    input  sender_data, sender_empty_n, receiver_full_n,
    output sender_deq, receiver_data, receiver_enq
  );

endinterface

// File: rtl/disaggregator.sv
// rtl/disaggregator.sv - splits wide FIFO words into narrow slices, lowest slice first
module disaggregator
  import fieldious_io_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int FETCH_WIDTH = DEFAULT_FETCH_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  disaggregator_if.slave bus,
  input  logic         change_fetch_width,
  input  fetch_width_t input_fetch_width
);

  localparam int           WORD_WIDTH = FETCH_WIDTH * DATA_WIDTH;
  localparam fetch_width_t MAX_FW     = fetch_width_t'(FETCH_WIDTH);
  localparam fetch_width_t ONE        = fetch_width_t'(1);

  logic [WORD_WIDTH-1:0] buf_q, buf_d;
  fetch_width_t          cnt_q, cnt_d;
  fetch_width_t          fw_q, fw_d;
  drain_state_t          state;
  logic                  enq, deq;

  // State is just whether any slices remain in the buffer
  always_comb state = (cnt_q == '0) ? ST_EMPTY : ST_DRAIN;

  // Handshakes and next buffer/count/width; a load wins over the shift of the last slice
  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    fw_d  = fw_q;
    enq   = 1'b0;
    deq   = 1'b0;
    if (!rst) begin
      case (state)
        ST_EMPTY: begin
          deq = bus.sender_empty_n && !change_fetch_width;
          if (change_fetch_width) fw_d = clamp_fetch_width(input_fetch_width, MAX_FW);
        end
        ST_DRAIN: begin
          enq = bus.receiver_full_n;
          deq = bus.sender_empty_n && !change_fetch_width && (cnt_q == ONE) && enq;
        end
        default: ;
      endcase
      if (enq) begin
        buf_d = buf_q >> DATA_WIDTH;
        cnt_d = cnt_q - ONE;
      end
      if (deq) begin
        buf_d = bus.sender_data;
        cnt_d = fw_q;
      end
    end
  end

  // Register buffer, remaining count and active width
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q <= '0;
      cnt_q <= '0;
      fw_q  <= MAX_FW;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      fw_q  <= fw_d;
    end
  end

  assign bus.sender_deq    = deq;
  assign bus.receiver_enq  = enq;
  assign bus.receiver_data = buf_q[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_disaggregator.sv
// tb/tb_disaggregator.sv - scoreboard bench for the disaggregator
module tb_disaggregator;
  import fieldious_io_pkg::*;

  localparam int DW = 11;
  localparam int FW = 2;
  localparam int WW = DW * FW;

  logic         clk = 1'b0;
  logic         rst;
  logic         change_fetch_width;
  fetch_width_t input_fetch_width;

  always #5 clk = ~clk;

  disaggregator_if #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW)) bus();

  disaggregator #(.DATA_WIDTH(DW), .FETCH_WIDTH(FW)) dut (
    .clk                (clk),
    .rst                (rst),
    .bus                (bus),
    .change_fetch_width (change_fetch_width),
    .input_fetch_width  (input_fetch_width)
  );

  logic [WW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  bit            deq_h[$];
  bit            enq_h[$];
  int            tests = 0;
  int            fails = 0;
  bit            up_en, rand_full, full_fix;
  bit            deq_s, enq_s;
  int            di, ei;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int count_ones(input bit q[$]);
    int n = 0;
    foreach (q[i]) if (q[i]) n++;
    return n;
  endfunction

  function automatic int first_one(input bit q[$]);
    foreach (q[i]) if (q[i]) return i;
    return -1;
  endfunction

  function automatic logic [WW-1:0] mk(input int hi, input int lo);
    logic [WW-1:0] w;
    w = {DW'(hi), DW'(lo)};
    return w;
  endfunction

  task automatic push_word(input logic [WW-1:0] w, input int width);
    fifo_q.push_back(w);
    for (int i = 0; i < width; i++) exp_q.push_back(w[i*DW +: DW]);
  endtask

  task automatic drive();
    bus.sender_empty_n  = up_en && (fifo_q.size() != 0);
    bus.sender_data     = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    bus.receiver_full_n = rand_full ? 1'($urandom_range(0, 1)) : full_fix;
  endtask

  task automatic sample();
    deq_s = bus.sender_deq;
    enq_s = bus.receiver_enq;
    if (!rst) begin
      if (enq_s) begin
        if (exp_q.size() == 0) check("spurious_enq", 1, 0);
        else check("slice_data", 32'(bus.receiver_data), 32'(exp_q.pop_front()));
      end
      if (!bus.receiver_full_n) check("enq_while_full", 32'(enq_s), 0);
      if (change_fetch_width) check("deq_during_change", 32'(deq_s), 0);
      deq_h.push_back(deq_s);
      enq_h.push_back(enq_s);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    if (deq_s) begin
      if (fifo_q.size() == 0) check("deq_from_empty", 1, 0);
      else void'(fifo_q.pop_front());
    end
    drive();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || fifo_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check("drain_timeout", 1, 0);
    repeat (3) tick();
  endtask

  task automatic wait_enq(input int budget);
    int n = 0;
    enq_s = 1'b0;
    while (!enq_s && n < budget) begin
      tick();
      n++;
    end
    if (!enq_s) check("enq_timeout", 1, 0);
  endtask

  task automatic set_width(input int w);
    change_fetch_width = 1'b1;
    input_fetch_width  = fetch_width_t'(w);
    repeat (2) tick();
    change_fetch_width = 1'b0;
    tick();
  endtask

  task automatic clear_hist();
    deq_h.delete();
    enq_h.delete();
  endtask

  initial begin
    rst = 1'b1;
    change_fetch_width = 1'b0;
    input_fetch_width = '0;
    up_en = 1'b1;
    rand_full = 1'b0;
    full_fix = 1'b1;

    // reset: handshakes forced low even with a word waiting upstream
    push_word(mk(2, 1), 2);
    drive();
    repeat (3) begin
      tick();
      check("rst_deq", 32'(deq_s), 0);
      check("rst_enq", 32'(enq_s), 0);
    end
    check("rst_data", 32'(bus.receiver_data), 0);

    // single word, width 2
    rst = 1'b0;
    clear_hist();
    drain(20);
    di = first_one(deq_h);
    ei = first_one(enq_h);
    check("t1_deq_count", count_ones(deq_h), 1);
    check("t1_enq_count", count_ones(enq_h), 2);
    check("t1_latency", ei, di + 1);
    check("t1_consecutive", 32'(enq_h[ei+1]), 1);

    // back-to-back words, no bubble
    clear_hist();
    push_word(mk(2, 1), 2);
    push_word(mk(4, 3), 2);
    push_word(mk(6, 5), 2);
    drive();
    drain(40);
    di = first_one(deq_h);
    ei = first_one(enq_h);
    check("t2_deq_count", count_ones(deq_h), 3);
    check("t2_enq_count", count_ones(enq_h), 6);
    check("t2_latency", ei, di + 1);
    for (int k = 0; k < 6; k++) check("t2_no_gap", 32'(enq_h[ei+k]), 1);
    check("t2_deq_c2", 32'(deq_h[di+2]), 1);
    check("t2_deq_c4", 32'(deq_h[di+4]), 1);

    // random downstream backpressure
    rand_full = 1'b1;
    for (int k = 0; k < 64; k++) push_word(WW'($urandom), 2);
    drive();
    drain(3000);
    rand_full = 1'b0;
    drive();
    check("t3_leftover", exp_q.size(), 0);

    // width 1: only slice 0 of each word
    set_width(1);
    clear_hist();
    push_word(mk(7, 9), 1);
    push_word(mk(5, 3), 1);
    drive();
    drain(30);
    check("t4_deq_count", count_ones(deq_h), 2);
    check("t4_enq_count", count_ones(enq_h), 2);

    // width 0 clamps to 2
    set_width(0);
    clear_hist();
    push_word(mk(2, 1), 2);
    drive();
    drain(30);
    check("t4_clamp0_enq", count_ones(enq_h), 2);

    // change requested mid-drain: old word completes, then new width
    push_word(mk(2, 1), 2);
    push_word(mk(4, 3), 1);
    drive();
    wait_enq(20);
    change_fetch_width = 1'b1;
    input_fetch_width = fetch_width_t'(1);
    clear_hist();
    repeat (3) tick();
    check("t5_slice2", count_ones(enq_h), 1);
    check("t5_no_deq", count_ones(deq_h), 0);
    change_fetch_width = 1'b0;
    clear_hist();
    drain(30);
    check("t5_after_enq", count_ones(enq_h), 1);

    // width above max clamps to 2
    set_width(3);
    clear_hist();
    push_word(mk(12, 11), 2);
    drive();
    drain(30);
    check("t4_clamp3_enq", count_ones(enq_h), 2);

    // reset with one slice remaining
    push_word(mk(2, 1), 2);
    drive();
    wait_enq(20);
    up_en = 1'b0;
    rst = 1'b1;
    drive();
    exp_q.delete();
    tick();
    check("t6_rst_enq", 32'(enq_s), 0);
    check("t6_rst_deq", 32'(deq_s), 0);
    rst = 1'b0;
    tick();
    check("t6_post_enq", 32'(enq_s), 0);
    check("t6_post_deq", 32'(deq_s), 0);
    check("t6_post_data", 32'(bus.receiver_data), 0);
    clear_hist();
    up_en = 1'b1;
    push_word(mk(6, 5), 2);
    drive();
    drain(30);
    check("t6_restart_enq", count_ones(enq_h), 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
